// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage: upstream
// (in_*) and downstream (out_*) sides seen from the stage itself.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // the stage consumes upstream beats and produces downstream beats
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // the surrounding pipeline drives the opposite direction
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a one-entry skid, masked flush and a
// saturating counter of entries discarded by flushes.
module pipe_skid_reg #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] FLUSH_MASK = {WIDTH{1'b1}},
  parameter int               CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipe_skid_reg_if.slave       bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] flush_drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_r, state_nx;
  logic [WIDTH-1:0]     main_r, main_nx;
  logic [WIDTH-1:0]     skid_r, skid_nx;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nx;
  logic [1:0]           occ_r, occ_nx;
  logic                 in_ready_r, in_ready_nx;
  logic                 out_valid_r, out_valid_nx;
  logic                 in_fire_s, out_fire_s;
  logic [1:0]           drop_s;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
    if (sum[CNT_WIDTH]) begin
      sat_add = {CNT_WIDTH{1'b1}};
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;
  // occupancy never underflows here: out_fire implies occ >= 1, in_fire implies occ <= 1
  assign drop_s     = occ_r - {1'b0, out_fire_s} + {1'b0, in_fire_s};

  // next-state, payload movement and flush handling
  always_comb begin
    state_nx = state_r;
    main_nx  = main_r;
    skid_nx  = skid_r;
    cnt_nx   = cnt_r;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = main_r & ~FLUSH_MASK;
      skid_nx  = {WIDTH{1'b0}};
      cnt_nx   = sat_add(cnt_r, drop_s);
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_nx  = bus.in_data;
            state_nx = BUSY;
          end else begin
            state_nx = EMPTY;
          end
        end
        BUSY: begin
          if (in_fire_s && out_fire_s) begin
            main_nx  = bus.in_data;
            state_nx = BUSY;
          end else if (in_fire_s) begin
            skid_nx  = bus.in_data;
            state_nx = FULL;
          end else if (out_fire_s) begin
            state_nx = EMPTY;
          end else begin
            state_nx = BUSY;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            main_nx  = skid_r;
            state_nx = BUSY;
          end else begin
            state_nx = FULL;
          end
        end
        default: begin
          state_nx = EMPTY;
        end
      endcase
    end
  end

  // output flags are precomputed from the next state so they leave as flops
  always_comb begin
    occ_nx       = 2'd0;
    in_ready_nx  = 1'b1;
    out_valid_nx = 1'b0;
    case (state_nx)
      EMPTY: begin
        occ_nx       = 2'd0;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
      end
      BUSY: begin
        occ_nx       = 2'd1;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b1;
      end
      FULL: begin
        occ_nx       = 2'd2;
        in_ready_nx  = 1'b0;
        out_valid_nx = 1'b1;
      end
      default: begin
        occ_nx       = 2'd0;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // state, storage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      main_r      <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      occ_r       <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      main_r      <= main_nx;
      skid_r      <= skid_nx;
      cnt_r       <= cnt_nx;
      occ_r       <= occ_nx;
      in_ready_r  <= in_ready_nx;
      out_valid_r <= out_valid_nx;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = main_r;
  assign occupancy      = occ_r;
  assign flush_drop_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: FIFO scoreboard on the handshakes plus
// hand-computed checks of occupancy, flush masking and the drop counter.
module tb_pipe_skid_reg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] flush_drop_cnt;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_reg #(
    .WIDTH(WIDTH),
    .FLUSH_MASK(16'hFF00),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus),
    .occupancy(occupancy),
    .flush_drop_cnt(flush_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: accepted beats are queued, delivered beats are compared in order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got 0x%0h, expected no beat", bus.out_data);
        end else begin
          check("sb_data", {16'h0, bus.out_data}, {16'h0, exp_q.pop_front()});
          pops++;
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b0;
    step();
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("rst_occ", {30'h0, occupancy}, 32'h0);
    check("rst_data", {16'h0, bus.out_data}, 32'h0);
    rst_n = 1'b1;
    step();

    // streaming: one beat per cycle, one cycle latency
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      step();
      check("stream_occ", {30'h0, occupancy}, 32'h1);
      check("stream_data", {16'h0, bus.out_data}, 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_drain_occ", {30'h0, occupancy}, 32'h0);

    // back-pressure from the third beat
    bus.in_valid = 1'b1; bus.in_data = 16'h0001; step();
    bus.in_data = 16'h0002; step();
    bus.in_data = 16'h0003; bus.out_ready = 1'b0; step();
    check("bp_data", {16'h0, bus.out_data}, 32'h0002);
    check("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("bp_occ", {30'h0, occupancy}, 32'h2);
    bus.in_data = 16'h0004; step();
    check("bp_hold_data", {16'h0, bus.out_data}, 32'h0002);
    check("bp_hold_occ", {30'h0, occupancy}, 32'h2);
    bus.out_ready = 1'b1; step();
    check("bp_rel1_data", {16'h0, bus.out_data}, 32'h0003);
    check("bp_rel1_occ", {30'h0, occupancy}, 32'h1);
    step();
    check("bp_rel2_data", {16'h0, bus.out_data}, 32'h0004);
    bus.in_valid = 1'b0; step();
    check("bp_empty_valid", {31'h0, bus.out_valid}, 32'h0);

    // masked flush of a full stage
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'hABCD; step();
    bus.in_data = 16'h1234; step();
    check("fl_occ_full", {30'h0, occupancy}, 32'h2);
    bus.in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    check("fl_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("fl_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("fl_data", {16'h0, bus.out_data}, 32'h00CD);
    check("fl_cnt", {30'h0, flush_drop_cnt}, 32'h2);

    // flush with simultaneous in_fire and out_fire
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 16'h5555; step();
    bus.in_data = 16'h6666; flush = 1'b1; step();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fls_occ", {30'h0, occupancy}, 32'h0);
    check("fls_cnt", {30'h0, flush_drop_cnt}, 32'h3);
    check("fls_data", {16'h0, bus.out_data}, 32'h0055);

    // asynchronous reset with two entries held
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h0A0A; step();
    bus.in_data = 16'h0B0B; step();
    check("ar_occ_full", {30'h0, occupancy}, 32'h2);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("ar_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("ar_occ", {30'h0, occupancy}, 32'h0);
    check("ar_data", {16'h0, bus.out_data}, 32'h0);
    check("ar_cnt", {30'h0, flush_drop_cnt}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // saturation of the 2-bit drop counter
    for (int k = 0; k < 3; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h0100 + k); step();
      bus.in_data = 16'(16'h0200 + k); step();
      bus.in_valid = 1'b0; flush = 1'b1; step();
      flush = 1'b0;
      check("sat_cnt", {30'h0, flush_drop_cnt}, (k == 0) ? 32'h2 : 32'h3);
    end

    step();
    check("sb_pops", 32'(pops), 32'd21);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
